// File: rtl/key_debounce_toggle.sv
// Purpose: per-key 2-flop synchronizer, stability-count debouncer, press/release pulses and toggle latch.
// Latency: a held key_raw change reaches key_level STABLE_CYCLES+2 edges later; pulses and toggle update on that same edge.
// Backpressure: none; free-running, every output is a register refreshed each cycle.
module key_debounce_toggle #(
    parameter int N_KEYS        = 3,
    parameter int STABLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_toggle
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    // The counter saturates here: reaching it on a mismatch accepts the new level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [CNT_W-1:0]  cnt [N_KEYS];

    // Two-flop synchronizer bringing the asynchronous buttons into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: count consecutive mismatches, accept on the last one,
    // and emit the edge pulses and toggle on the same edge the level moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_toggle  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (sync2[i] == key_level[i]) begin
                    // Input agrees with the accepted level: any partial run was a glitch.
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    key_level[i]   <= sync2[i];
                    cnt[i]         <= '0;
                    key_press[i]   <= sync2[i];
                    key_release[i] <= ~sync2[i];
                    if (sync2[i]) begin
                        key_toggle[i] <= ~key_toggle[i];
                    end
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce_toggle.sv
// Purpose: self-checking bench for key_debounce_toggle with a window-based reference model and scoreboard.
// Latency: expectations are queued one edge ahead and checked just after that edge.
// Backpressure: none; the monitor consumes one expectation per clock.
module tb_key_debounce_toggle;

    localparam int N  = 3;
    localparam int SC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_raw = '0;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_toggle;

    key_debounce_toggle #(.N_KEYS(N), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] tog;
    } obs_t;

    obs_t exp_q[$];
    int   pushed = 0;
    int   popped = 0;

    // Reference model: a key changes when the last SC synchronized samples
    // seen since reset all disagree with the accepted level.
    logic [N-1:0]  m_level = '0, m_press = '0, m_rel = '0, m_tog = '0;
    logic [N-1:0]  m_s1 = '0, m_s2 = '0;
    logic [SC-1:0] win  [N];
    int            fill [N];

    task automatic model_edge(input logic [N-1:0] raw, input logic r);
        if (r) begin
            m_level = '0; m_press = '0; m_rel = '0; m_tog = '0;
            m_s1 = '0; m_s2 = '0;
            for (int k = 0; k < N; k++) begin
                win[k]  = '0;
                fill[k] = 0;
            end
        end else begin
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < N; k++) begin
                win[k] = {win[k][SC-2:0], m_s2[k]};
                if (fill[k] < SC) fill[k]++;
                if (fill[k] == SC && win[k] == (m_level[k] ? {SC{1'b0}} : {SC{1'b1}})) begin
                    m_level[k] = ~m_level[k];
                    if (m_level[k]) begin
                        m_press[k] = 1'b1;
                        m_tog[k]   = ~m_tog[k];
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        exp_q.push_back({m_level, m_press, m_rel, m_tog});
        pushed++;
    endtask

    // Monitor: every clock the DUT presents a full output word; compare it with the queue head.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk("scoreboard", {20'd0, key_level, key_press, key_release, key_toggle}, {20'd0, e});
            end
        end
    end

    // Observation tallies used by the directed checks.
    int n_press [N];
    int n_rel   [N];
    int coincide = 0;

    task automatic step(input logic [N-1:0] raw, input logic r);
        @(negedge clk);
        key_raw = raw;
        rst     = r;
        model_edge(raw, r);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_press[k] += int'(key_press[k]);
            n_rel[k]   += int'(key_release[k]);
        end
        if ((key_press & key_release) != '0) coincide++;
    endtask

    task automatic do_reset(input logic [N-1:0] raw);
        for (int i = 0; i < 3; i++) begin
            step(raw, 1'b1);
            chk("rst_zero", {20'd0, key_level, key_press, key_release, key_toggle}, 32'd0);
        end
        for (int k = 0; k < N; k++) begin
            n_press[k] = 0;
            n_rel[k]   = 0;
        end
        coincide = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int           first;
        logic         seen;
        int           hold [N];
        logic [N-1:0] rv;

        // Keys held through reset: fresh press 10 edges after release.
        do_reset(3'b111);
        for (int i = 1; i <= 9; i++) step(3'b111, 1'b0);
        chk("rst_lvl_e9", 32'(key_level), 32'd0);
        step(3'b111, 1'b0);
        chk("rst_lvl_e10", 32'(key_level), 32'h7);
        chk("rst_press_e10", 32'(key_press), 32'h7);
        chk("rst_tog_e10", 32'(key_toggle), 32'h7);
        step(3'b111, 1'b0);
        chk("rst_press_e11", 32'(key_press), 32'd0);

        // Clean press on key 2.
        do_reset(3'b000);
        for (int i = 1; i <= 9; i++) step(3'b100, 1'b0);
        chk("clean_lvl_e9", 32'(key_level), 32'd0);
        step(3'b100, 1'b0);
        chk("clean_lvl_e10", 32'(key_level), 32'h4);
        chk("clean_press_e10", 32'(key_press), 32'h4);
        chk("clean_tog_e10", 32'(key_toggle), 32'h4);
        step(3'b100, 1'b0);
        chk("clean_press_e11", 32'(key_press), 32'd0);
        chk("clean_press_cnt", 32'(n_press[2]), 32'd1);

        // Glitch on key 1: 5-cycle pulse must be rejected.
        do_reset(3'b000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step((i < 5) ? 3'b010 : 3'b000, 1'b0);
            seen = seen | key_level[1] | key_toggle[1];
        end
        chk("glitch_lvl_tog", 32'(seen), 32'd0);
        chk("glitch_press", 32'(n_press[1]), 32'd0);

        // Bounce on key 0, then held high.
        do_reset(3'b000);
        for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? 3'b001 : 3'b000, 1'b0);
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            step(3'b001, 1'b0);
            if (key_press[0] && first == 0) first = i;
        end
        chk("bounce_cnt", 32'(n_press[0]), 32'd1);
        chk("bounce_lat", 32'(first), 32'd10);

        // Press, release, press again on key 2.
        do_reset(3'b000);
        for (int i = 0; i < 15; i++) step(3'b100, 1'b0);
        chk("rt_tog_1", 32'(key_toggle[2]), 32'd1);
        for (int i = 0; i < 15; i++) step(3'b000, 1'b0);
        chk("rt_tog_hold", 32'(key_toggle[2]), 32'd1);
        chk("rt_rel_cnt", 32'(n_rel[2]), 32'd1);
        chk("rt_lvl_low", 32'(key_level[2]), 32'd0);
        for (int i = 0; i < 15; i++) step(3'b100, 1'b0);
        chk("rt_tog_0", 32'(key_toggle[2]), 32'd0);
        chk("rt_press_cnt", 32'(n_press[2]), 32'd2);
        chk("rt_coincide", 32'(coincide), 32'd0);

        // Reset on edge 6 of a count on key 2.
        do_reset(3'b000);
        for (int i = 1; i <= 5; i++) step(3'b100, 1'b0);
        step(3'b100, 1'b1);
        chk("mid_rst_zero", {20'd0, key_level, key_press, key_release, key_toggle}, 32'd0);
        for (int i = 1; i <= 9; i++) step(3'b100, 1'b0);
        chk("mid_lvl_e9", 32'(key_level), 32'd0);
        chk("mid_no_pulse", 32'(n_press[2] + n_rel[2]), 32'd0);
        step(3'b100, 1'b0);
        chk("mid_lvl_e10", 32'(key_level), 32'h4);
        chk("mid_press_e10", 32'(key_press), 32'h4);

        // Randomized run: per-key hold lengths straddling the stability window, rare resets.
        rv = '0;
        for (int k = 0; k < N; k++) hold[k] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                hold[k]--;
                if (hold[k] <= 0) begin
                    rv[k]   = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 16));
                end
            end
            step(rv, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        chk("rand_coincide", 32'(coincide), 32'd0);

        @(negedge clk);
        chk("drain", 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
